// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use stall with
// configurable latency, redirect flush window, EX forwarding selects and a
// per-register scoreboard for multi-cycle (MUL/DIV) results.
module hazard_ctrl_sb #(
  parameter int NREG         = 32,
  parameter int RW           = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int FWD_EN       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_long,
  input  logic [RW-1:0]   idex_rs1,
  input  logic [RW-1:0]   idex_rs2,
  input  logic [RW-1:0]   idex_rd,
  input  logic            idex_reg_write,
  input  logic            idex_mem_read,
  input  logic            ex_long_issue,
  input  logic            exmem_reg_write,
  input  logic            exmem_mem_read,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            memwb_reg_write,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            long_done,
  input  logic [RW-1:0]   long_done_rd,
  input  logic            ex_redirect,
  output logic            stall_if,
  output logic            stall_id,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [NREG-1:0] sb_busy
);

  logic [2:0]      luse_cnt_q, luse_cnt_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [NREG-1:0] sb_busy_q, sb_busy_d;

  logic lu, raw_stall, sb_stall, flushing, hazard;

  // A used, nonzero ID source equal to a producing destination.
  function automatic logic src_match(input logic [RW-1:0] src, input logic use_src,
                                     input logic [RW-1:0] rd);
    return use_src && (src != '0) && (src == rd);
  endfunction

  // Source waits on a pending long op unless that op writes back this cycle.
  function automatic logic src_pending(input logic [RW-1:0] src, input logic use_src,
                                       input logic [NREG-1:0] busy, input logic done,
                                       input logic [RW-1:0] done_rd);
    return use_src && (src != '0) && busy[src] && !(done && (done_rd == src));
  endfunction

  // EX operand select; the younger EX/MEM ALU result wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (src == '0) return 2'b00;
    if (exmem_reg_write && !exmem_mem_read && (exmem_rd == src)) return 2'b10;
    if (memwb_reg_write && (memwb_rd == src)) return 2'b01;
    return 2'b00;
  endfunction

  // Hazard detection; ID contents are ignored while a flush window is open.
  always_comb begin
    flushing  = (flush_cnt_q != 3'd0);
    lu        = idex_mem_read && idex_reg_write &&
                (src_match(id_rs1, id_use_rs1, idex_rd) ||
                 src_match(id_rs2, id_use_rs2, idex_rd));
    raw_stall = (FWD_EN == 0) &&
                ((idex_reg_write && (src_match(id_rs1, id_use_rs1, idex_rd) ||
                                     src_match(id_rs2, id_use_rs2, idex_rd))) ||
                 (exmem_reg_write && (src_match(id_rs1, id_use_rs1, exmem_rd) ||
                                      src_match(id_rs2, id_use_rs2, exmem_rd))));
    sb_stall  = src_pending(id_rs1, id_use_rs1, sb_busy_q, long_done, long_done_rd) ||
                src_pending(id_rs2, id_use_rs2, sb_busy_q, long_done, long_done_rd) ||
                src_pending(id_rd,  id_long,    sb_busy_q, long_done, long_done_rd);
    hazard    = (!flushing && (lu || raw_stall || sb_stall)) || (luse_cnt_q != 3'd0);
  end

  // Next-state for the load-use counter, flush window and scoreboard.
  always_comb begin
    luse_cnt_d = luse_cnt_q;
    if (ex_redirect)              luse_cnt_d = 3'd0;
    else if (luse_cnt_q != 3'd0)  luse_cnt_d = luse_cnt_q - 3'd1;
    else if (lu && !flushing)     luse_cnt_d = 3'(LOAD_LAT - 1);

    flush_cnt_d = flush_cnt_q;
    if (ex_redirect)              flush_cnt_d = 3'(FLUSH_CYCLES - 1);
    else if (flushing)            flush_cnt_d = flush_cnt_q - 3'd1;

    sb_busy_d = sb_busy_q;
    if (long_done) sb_busy_d[long_done_rd] = 1'b0;
    if (ex_long_issue && (idex_rd != '0) && !ex_redirect) sb_busy_d[idex_rd] = 1'b1;
    sb_busy_d[0] = 1'b0;
  end

  // Control outputs; a redirect overrides stalls since the hazard is wrong-path.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (!rst) begin
      stall_if   = hazard && !ex_redirect;
      stall_id   = hazard && !ex_redirect;
      flush_ifid = ex_redirect || flushing;
      flush_idex = hazard || ex_redirect;
      if (FWD_EN != 0) begin
        fwd_a = fwd_sel(idex_rs1);
        fwd_b = fwd_sel(idex_rs2);
      end
    end
  end

  assign sb_busy = sb_busy_q;

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      luse_cnt_q  <= 3'd0;
      flush_cnt_q <= 3'd0;
      sb_busy_q   <= '0;
    end else begin
      luse_cnt_q  <= luse_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      sb_busy_q   <= sb_busy_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Bench for hazard_ctrl_sb: three configurations share one stimulus stream
// (main: LOAD_LAT=1/FWD_EN=1, L3: LOAD_LAT=3, NF: FWD_EN=0).
module tb_hazard_ctrl_sb;
  localparam int NREG = 32;
  localparam int RW   = 5;
  localparam int M = 0, L3 = 1, NF = 2;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] id_rs1, id_rs2, id_rd, idex_rs1, idex_rs2, idex_rd;
  logic [RW-1:0] exmem_rd, memwb_rd, long_done_rd;
  logic id_use_rs1, id_use_rs2, id_long, idex_reg_write, idex_mem_read, ex_long_issue;
  logic exmem_reg_write, exmem_mem_read, memwb_reg_write, long_done, ex_redirect;

  logic [2:0] sif, sid, fif, fex;
  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic [NREG-1:0] sb [3];
  // obs[k] = {stall_if, stall_id, flush_ifid, flush_idex, fwd_a, fwd_b, sb_busy}
  logic [NREG+7:0] obs [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .FWD_EN(1)) u_main (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_long(id_long), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .ex_long_issue(ex_long_issue),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .long_done(long_done),
    .long_done_rd(long_done_rd), .ex_redirect(ex_redirect),
    .stall_if(sif[0]), .stall_id(sid[0]), .flush_ifid(fif[0]), .flush_idex(fex[0]),
    .fwd_a(fa[0]), .fwd_b(fb[0]), .sb_busy(sb[0]));

  hazard_ctrl_sb #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .FWD_EN(1)) u_l3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_long(id_long), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .ex_long_issue(ex_long_issue),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .long_done(long_done),
    .long_done_rd(long_done_rd), .ex_redirect(ex_redirect),
    .stall_if(sif[1]), .stall_id(sid[1]), .flush_ifid(fif[1]), .flush_idex(fex[1]),
    .fwd_a(fa[1]), .fwd_b(fb[1]), .sb_busy(sb[1]));

  hazard_ctrl_sb #(.LOAD_LAT(1), .FLUSH_CYCLES(2), .FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_long(id_long), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .ex_long_issue(ex_long_issue),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .long_done(long_done),
    .long_done_rd(long_done_rd), .ex_redirect(ex_redirect),
    .stall_if(sif[2]), .stall_id(sid[2]), .flush_ifid(fif[2]), .flush_idex(fex[2]),
    .fwd_a(fa[2]), .fwd_b(fb[2]), .sb_busy(sb[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {sif[g], sid[g], fif[g], fex[g], fa[g], fb[g], sb[g]};
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0; id_long = 0;
    idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0; idex_reg_write = 0; idex_mem_read = 0;
    ex_long_issue = 0; exmem_reg_write = 0; exmem_mem_read = 0; exmem_rd = '0;
    memwb_reg_write = 0; memwb_rd = '0; long_done = 0; long_done_rd = '0; ex_redirect = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load_use();
    idex_mem_read = 1; idex_reg_write = 1; idex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  // Outputs stay 0 under reset even with hazards presented.
  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_load_use(); ex_redirect = 1; idex_rs1 = 3; exmem_reg_write = 1; exmem_rd = 3;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== '0) begin
        errors++; $display("FAIL reset_out[%0d]: got %h want 0", k, obs[k]);
      end
    end
    tick();
    idle();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== '0) begin
        errors++; $display("FAIL reset_idle[%0d]: got %h want 0", k, obs[k]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [3:0] want;
    do_reset();
    set_load_use();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k][39:36] !== 4'b1101) begin
        errors++; $display("FAIL lu_first[%0d]: got %b want 1101", k, obs[k][39:36]);
      end
    end
    tick();
    // EX now holds the inserted bubble; ID still holds the consumer
    idex_mem_read = 0; idex_reg_write = 0; idex_rd = 0;
    #1;
    checks++;
    if (obs[M][39:36] !== 4'b0000) begin
      errors++; $display("FAIL lu1_done: got %b want 0000", obs[M][39:36]);
    end
    for (int c = 1; c < 4; c++) begin
      want = (c < 3) ? 4'b1101 : 4'b0000;
      checks++;
      if (obs[L3][39:36] !== want) begin
        errors++; $display("FAIL lu3_cyc%0d: got %b want %b", c, obs[L3][39:36], want);
      end
      tick();
    end
    // same pattern on x0 never stalls
    idle();
    idex_mem_read = 1; idex_reg_write = 1; idex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k][39:36] !== 4'b0000) begin
        errors++; $display("FAIL lu_x0[%0d]: got %b want 0000", k, obs[k][39:36]);
      end
    end
    idle();
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1; #1;
    checks++;
    if (obs[M][39:36] !== 4'b0011) begin
      errors++; $display("FAIL redir_n: got %b want 0011", obs[M][39:36]);
    end
    tick(); ex_redirect = 0; #1;
    checks++;
    if (obs[M][39:36] !== 4'b0010) begin
      errors++; $display("FAIL redir_n1: got %b want 0010", obs[M][39:36]);
    end
    tick(); #1;
    checks++;
    if (obs[M][39:36] !== 4'b0000) begin
      errors++; $display("FAIL redir_n2: got %b want 0000", obs[M][39:36]);
    end
    // back-to-back redirects extend the window
    tick(); ex_redirect = 1; tick(); #1;
    checks++;
    if (obs[M][37] !== 1'b1) begin
      errors++; $display("FAIL redir2_n1: got %b want 1", obs[M][37]);
    end
    tick(); ex_redirect = 0; #1;
    checks++;
    if (obs[M][37:36] !== 2'b10) begin
      errors++; $display("FAIL redir2_n2: got %b want 10", obs[M][37:36]);
    end
    tick(); #1;
    checks++;
    if (obs[M][37] !== 1'b0) begin
      errors++; $display("FAIL redir2_n3: got %b want 0", obs[M][37]);
    end
    // redirect coincident with load-use on the LOAD_LAT=3 instance
    do_reset();
    set_load_use(); ex_redirect = 1; #1;
    checks++;
    if (obs[L3][39:36] !== 4'b0011) begin
      errors++; $display("FAIL redir_lu: got %b want 0011", obs[L3][39:36]);
    end
    tick(); ex_redirect = 0; #1;
    checks++;
    if (obs[L3][39:36] !== 4'b0010) begin
      errors++; $display("FAIL redir_lu_window: got %b want 0010", obs[L3][39:36]);
    end
    tick(); idle(); #1;
    checks++;
    if (obs[L3][39:36] !== 4'b0000) begin
      errors++; $display("FAIL redir_lu_cleared: got %b want 0000", obs[L3][39:36]);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    idex_rs1 = 3; idex_rs2 = 3; exmem_reg_write = 1; exmem_rd = 3;
    memwb_reg_write = 1; memwb_rd = 3; #1;
    checks++;
    if ({fa[M], fb[M], fa[NF], fb[NF]} !== 8'b10100000) begin
      errors++; $display("FAIL fwd_exmem: got %b%b nf %b%b want 1010 nf 0000",
                         fa[M], fb[M], fa[NF], fb[NF]);
    end
    exmem_mem_read = 1; #1;
    checks++;
    if (fa[M] !== 2'b01) begin
      errors++; $display("FAIL fwd_load_memwb: got %b want 01", fa[M]);
    end
    exmem_mem_read = 0; exmem_rd = 4; idex_rs2 = 4; #1;
    checks++;
    if ({fa[M], fb[M]} !== 4'b0110) begin
      errors++; $display("FAIL fwd_split: got %b%b want 0110", fa[M], fb[M]);
    end
    memwb_rd = 5; exmem_reg_write = 0; #1;
    checks++;
    if ({fa[M], fb[M]} !== 4'b0000) begin
      errors++; $display("FAIL fwd_none: got %b%b want 0000", fa[M], fb[M]);
    end
    idex_rs1 = 0; idex_rs2 = 0; exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; #1;
    checks++;
    if ({fa[M], fb[M]} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0: got %b%b want 0000", fa[M], fb[M]);
    end
    // FWD_EN=0: RAW on EX/MEM stalls one cycle, MEM/WB does not
    idle(); id_rs1 = 3; id_use_rs1 = 1; exmem_reg_write = 1; exmem_rd = 3; #1;
    checks++;
    if ({obs[NF][39:36], obs[M][39:36]} !== 8'b11010000) begin
      errors++; $display("FAIL raw_exmem: got nf %b main %b want 1101 0000",
                         obs[NF][39:36], obs[M][39:36]);
    end
    tick(); exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 3; #1;
    checks++;
    if (obs[NF][39:36] !== 4'b0000) begin
      errors++; $display("FAIL raw_memwb: got %b want 0000", obs[NF][39:36]);
    end
    memwb_reg_write = 0; idex_reg_write = 1; idex_rd = 3; #1;
    checks++;
    if ({obs[NF][39:36], obs[M][39:36]} !== 8'b11010000) begin
      errors++; $display("FAIL raw_idex: got nf %b main %b want 1101 0000",
                         obs[NF][39:36], obs[M][39:36]);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    do_reset();
    ex_long_issue = 1; idex_rd = 7; #1;
    checks++;
    if (sb[M] !== 32'h0) begin
      errors++; $display("FAIL sb_before_edge: got %h want 0", sb[M]);
    end
    tick(); idle(); id_rs1 = 7; id_use_rs1 = 1; #1;
    checks++;
    if ({sb[M], obs[M][39:36]} !== {32'h80, 4'b1101}) begin
      errors++; $display("FAIL sb_set: got %h/%b want 80/1101", sb[M], obs[M][39:36]);
    end
    tick(); tick(); #1;
    checks++;
    if (obs[M][39:36] !== 4'b1101) begin
      errors++; $display("FAIL sb_hold: got %b want 1101", obs[M][39:36]);
    end
    long_done = 1; long_done_rd = 7; #1;
    checks++;
    if ({sb[M], obs[M][39:36]} !== {32'h80, 4'b0000}) begin
      errors++; $display("FAIL sb_bypass: got %h/%b want 80/0000", sb[M], obs[M][39:36]);
    end
    tick(); long_done = 0; #1;
    checks++;
    if (sb[M] !== 32'h0) begin
      errors++; $display("FAIL sb_cleared: got %h want 0", sb[M]);
    end
    idle(); ex_long_issue = 1; idex_rd = 7; tick();
    long_done = 1; long_done_rd = 7; tick(); idle(); #1;
    checks++;
    if (sb[M] !== 32'h80) begin
      errors++; $display("FAIL sb_set_wins: got %h want 80", sb[M]);
    end
    ex_long_issue = 1; idex_rd = 0; tick();
    idex_rd = 4; ex_redirect = 1; tick(); idle(); #1;
    checks++;
    if (sb[M] !== 32'h80) begin
      errors++; $display("FAIL sb_x0_redirect: got %h want 80", sb[M]);
    end
  endtask

  task automatic test_waw_async_reset();
    do_reset();
    ex_long_issue = 1; idex_rd = 9; tick(); idle();
    id_long = 1; id_rd = 9; set_load_use(); #1;
    checks++;
    if (obs[M][39:36] !== 4'b1101) begin
      errors++; $display("FAIL waw_stall: got %b want 1101", obs[M][39:36]);
    end
    tick();
    idex_mem_read = 0; idex_reg_write = 0; idex_rd = 0; #1;
    checks++;
    if ({obs[M][39:36], obs[L3][39:36]} !== 8'b11011101) begin
      errors++; $display("FAIL mid_stall: got main %b l3 %b want 1101 1101",
                         obs[M][39:36], obs[L3][39:36]);
    end
    rst = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== '0) begin
        errors++; $display("FAIL async_rst[%0d]: got %h want 0", k, obs[k]);
      end
    end
    rst = 1'b0; #1;
    checks++;
    if ({obs[M], obs[L3][39:36]} !== '0) begin
      errors++; $display("FAIL after_rst: got main %h l3 %b want 0", obs[M], obs[L3][39:36]);
    end
    idle();
  endtask

  function automatic bit hit(input logic [RW-1:0] s, input logic u, input logic [RW-1:0] rd);
    return u && s != 0 && s == rd;
  endfunction

  function automatic bit waits(input logic [RW-1:0] r, input logic u, input logic [31:0] p);
    return u && r != 0 && p[r] && !(long_done && long_done_rd == r);
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [RW-1:0] s);
    if (s != 0 && exmem_reg_write && !exmem_mem_read && exmem_rd == s) return 2'b10;
    if (s != 0 && memwb_reg_write && memwb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [RW-1:0] rreg();
    return ($urandom_range(0, 9) == 0) ? RW'($urandom_range(0, 31)) : RW'($urandom_range(0, 3));
  endfunction

  // Random traffic against a model of stall-cycles-remaining and pending writes.
  task automatic test_random();
    int lrem [3];
    int frem [3];
    logic [31:0] pend [3];
    int ll [3];
    bit fe [3];
    bit lu, raw, sbw, hz, fl;
    logic [NREG+7:0] exp_v;
    ll[0] = 1; ll[1] = 3; ll[2] = 1;
    fe[0] = 1; fe[1] = 1; fe[2] = 0;
    for (int k = 0; k < 3; k++) begin lrem[k] = 0; frem[k] = 0; pend[k] = '0; end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_rs1 = rreg(); id_rs2 = rreg(); id_rd = rreg();
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_long = ($urandom_range(0, 3) == 0);
      idex_rs1 = rreg(); idex_rs2 = rreg(); idex_rd = rreg();
      idex_reg_write = 1'($urandom); idex_mem_read = 1'($urandom);
      ex_long_issue = ($urandom_range(0, 3) == 0);
      exmem_reg_write = 1'($urandom); exmem_mem_read = 1'($urandom); exmem_rd = rreg();
      memwb_reg_write = 1'($urandom); memwb_rd = rreg();
      long_done = ($urandom_range(0, 2) == 0); long_done_rd = rreg();
      ex_redirect = ($urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        fl  = frem[k] > 0;
        lu  = idex_mem_read && idex_reg_write &&
              (hit(id_rs1, id_use_rs1, idex_rd) || hit(id_rs2, id_use_rs2, idex_rd));
        raw = !fe[k] &&
              ((idex_reg_write && (hit(id_rs1, id_use_rs1, idex_rd) || hit(id_rs2, id_use_rs2, idex_rd))) ||
               (exmem_reg_write && (hit(id_rs1, id_use_rs1, exmem_rd) || hit(id_rs2, id_use_rs2, exmem_rd))));
        sbw = waits(id_rs1, id_use_rs1, pend[k]) || waits(id_rs2, id_use_rs2, pend[k]) ||
              waits(id_rd, id_long, pend[k]);
        hz  = (!fl && (lu || raw || sbw)) || lrem[k] > 0;
        exp_v = {hz && !ex_redirect, hz && !ex_redirect, ex_redirect || fl, hz || ex_redirect,
                 fe[k] ? fwd_ref(idex_rs1) : 2'b00, fe[k] ? fwd_ref(idex_rs2) : 2'b00, pend[k]};
        checks++;
        if (obs[k] !== exp_v) begin
          errors++;
          if (errors < 20) $display("FAIL rand cyc%0d inst%0d: got %h want %h", cyc, k, obs[k], exp_v);
        end
        if (ex_redirect) lrem[k] = 0;
        else if (lrem[k] > 0) lrem[k] = lrem[k] - 1;
        else if (lu && !fl) lrem[k] = ll[k] - 1;
        frem[k] = ex_redirect ? 1 : (fl ? frem[k] - 1 : 0);
        if (long_done) pend[k][long_done_rd] = 1'b0;
        if (ex_long_issue && idex_rd != 0 && !ex_redirect) pend[k][idex_rd] = 1'b1;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    test_reset();
    test_load_use();
    test_redirect();
    test_forwarding();
    test_scoreboard();
    test_waw_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
Parametrised pipeline hazard controller for the 5-stage RV32 core; successor to the single-cycle load-use/redirect unit.
- Adds configurable load-use latency, a programmable redirect flush window, optional EX-stage forwarding selects, and a per-register scoreboard for multi-cycle (MUL/DIV) results.
- Sits beside the ID/EX control path.
- Drives the IF/ID and ID/EX stall/flush controls and the EX operand muxes.

Parameters:
NREG, 32, architectural register count (x0 hard-wired zero)
RW, 5, register index width (log2 NREG)
LOAD_LAT, 1, total stall cycles for a load-use hazard (1..7)
FLUSH_CYCLES, 2, cycles flush_ifid stays high per redirect, counting the redirect cycle (1..7)
FWD_EN, 1, 1 = generate forwarding selects; 0 = stall on every EX/MEM RAW and hold fwd_a/fwd_b at 0

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_rs1, id_rs2  in  RW  ID source registers
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
id_rd  in  RW  ID destination
id_long  in  1  ID instruction is a multi-cycle op
idex_rs1, idex_rs2  in  RW  EX source registers
idex_rd  in  RW  EX destination
idex_reg_write, idex_mem_read  in  1  EX writes rd / EX is a load
ex_long_issue  in  1  EX hands a multi-cycle op (dest idex_rd) to the MUL/DIV unit this cycle
exmem_reg_write, exmem_mem_read  in  1  MEM-stage controls
exmem_rd  in  RW  MEM destination
memwb_reg_write  in  1  WB writes
memwb_rd  in  RW  WB destination
long_done  in  1  MUL/DIV result written back this cycle
long_done_rd  in  RW  destination of completing op
ex_redirect  in  1  taken branch/jal/jalr resolved in EX
stall_if, stall_id  out  1  hold PC / hold IF/ID
flush_ifid, flush_idex  out  1  bubble IF/ID / bubble ID/EX
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
sb_busy  out  NREG  scoreboard pending-write vector (debug/verification)

Behaviour:
- **Reset values.** All state clears asynchronously on rst:
  - luse_cnt=0, flush_cnt=0, sb_busy=0.
  - While rst=1, all outputs are 0.
- **Match rule.** A register match on source s requires the register != 0 and the matching id_use_*. Index compares are full RW-bit equality.
- **load-use hazard (lu):** idex_mem_read & idex_reg_write & idex_rd matches a used ID source.
  - On lu with luse_cnt==0, load luse_cnt=LOAD_LAT-1.
  - stall_if/stall_id/flush_idex are high when lu or luse_cnt!=0.
  - luse_cnt decrements each cycle while nonzero.
  - LOAD_LAT=1 gives exactly one stall cycle.
- **raw_stall** (FWD_EN=0 only): a used ID source matches idex_rd (idex_reg_write) or exmem_rd (exmem_reg_write). It stalls IF/ID and flushes ID/EX for that cycle. A MEM/WB match does not stall; the regfile WB bypass covers it.
- **Forwarding** (FWD_EN=1), per EX operand:
  - 10 if exmem_reg_write & !exmem_mem_read & exmem_rd==src!=0.
  - Otherwise 01 if memwb_reg_write & memwb_rd==src!=0.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- **Scoreboard.**
  - Set: ex_long_issue & idex_rd!=0 & !ex_redirect sets sb_busy[idex_rd] on the next edge.
  - Clear: long_done clears sb_busy[long_done_rd].
  - Set and clear of the same index in one cycle leaves the bit set.
  - Bit 0 is never set.
- **sb_stall:**
  - A used ID source has sb_busy set and is not being cleared this cycle (long_done & long_done_rd==src bypasses).
  - OR id_long & id_rd!=0 & sb_busy[id_rd] (WAW). The same-cycle long_done bypass applies here too.
  - sb_stall stalls IF/ID and flushes ID/EX.
- **Redirect.**
  - ex_redirect loads flush_cnt=FLUSH_CYCLES-1.
  - flush_ifid = ex_redirect | (flush_cnt!=0). flush_cnt decrements while nonzero.
  - A redirect inside an active window reloads the counter.
  - flush_idex is also high on ex_redirect.
- **Priority.**
  - ex_redirect forces stall_if=stall_id=0 and clears luse_cnt to 0 on the same edge. Wrong-path hazards are dropped.
  - While flush_cnt!=0, lu/raw_stall/sb_stall are ignored, because the ID contents are being flushed.
- **Output timing.** Outputs are combinational from inputs plus registered state, so a hazard produces a same-cycle response. The counters and sb_busy update on posedge clk.

Test Plan:
- **Load-use, LOAD_LAT=1 vs 3.** Load x5 in EX, ID uses rs1=x5. LOAD_LAT=1: stall/flush_idex high 1 cycle. LOAD_LAT=3: high exactly 3 consecutive cycles, then low. Same stimulus with rd=x0: no stall.
- **Redirect window.** FLUSH_CYCLES=2, ex_redirect pulse at cycle N:
  - flush_ifid high N and N+1; flush_idex high only at N.
  - A second redirect at N+1 extends flush_ifid through N+2.
  - A redirect coincident with lu gives stall_if=0 and luse_cnt cleared.
- **Forwarding.** exmem_rd=x3 (ALU) and memwb_rd=x3 with idex_rs1=x3: fwd_a=10. exmem_mem_read=1 instead: fwd_a=01. FWD_EN=0: fwd_a=00 and ID using x3 stalls 1 cycle.
- **Scoreboard.**
  - ex_long_issue to x7: sb_busy[7]=1 next cycle.
  - ID reading x7 stalls until long_done with rd=7. The stall drops in the long_done cycle; the bit is 0 after the edge.
  - Simultaneous long_done rd=7 and new issue rd=7: bit stays 1.
- **WAW and reset.**
  - id_long with id_rd=x9 while sb_busy[9]=1: stall.
  - Async rst asserted mid-stall (luse_cnt=2, busy nonzero): all outputs and sb_busy read 0 immediately, before the next clk edge.
